// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Multicycle FSM sequencing a stack machine datapath: fetch,
//                decode, operand pops, ALU execute, write-back and jumps.
//                Optional trap support is compiled in with `define CU_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] INSTR_IN,
    input  logic [DATA_WIDTH-1:0] ARG_IN,
    input  logic                  COMPARE_IN,
    input  logic                  OVERFLOW_IN,
    input  logic [ADDR_WIDTH-1:0] TOS_IN,
    output logic                  imem_req,
    output logic                  CTRL_REG_INSTR,
    output logic                  CTRL_REG_OP1,
    output logic                  CTRL_REG_OP2,
    output logic                  CTRL_STACK_PUSH,
    output logic                  CTRL_STACK_POP,
    output logic [1:0]            SEL_STACK_SRC,
    output logic [3:0]            SEL_ULA,
    output logic                  CTRL_REG_PC,
    output logic                  SEL_MUX_PC,
    output logic                  halted,
    output logic                  trap
);

`ifdef CU_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Opcode map
    localparam logic [DATA_WIDTH-1:0] OP_NOP       = DATA_WIDTH'(8'h00);
    localparam logic [DATA_WIDTH-1:0] OP_PUSH      = DATA_WIDTH'(8'h01);
    localparam logic [DATA_WIDTH-1:0] OP_POP       = DATA_WIDTH'(8'h02);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_FIRST = DATA_WIDTH'(8'h10);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_LAST  = DATA_WIDTH'(8'h17);
    localparam logic [DATA_WIDTH-1:0] OP_CMP       = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] OP_JMP       = DATA_WIDTH'(8'h30);
    localparam logic [DATA_WIDTH-1:0] OP_JMPT      = DATA_WIDTH'(8'h31);
    localparam logic [DATA_WIDTH-1:0] OP_HALT      = DATA_WIDTH'(8'hFF);

    localparam logic [3:0] ULA_CMP  = 4'h8;
    localparam logic [3:0] ULA_TEST = 4'hE;

    localparam logic [1:0] SRC_ARG = 2'd0;
    localparam logic [1:0] SRC_ALU = 2'd1;
    localparam logic [1:0] SRC_CMP = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_POP_A  = 4'd3,
        S_POP_B  = 4'd4,
        S_EXEC   = 4'd5,
        S_WRITE  = 4'd6,
        S_JUMP   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] instr;

    // Decoded view of the latched opcode
    logic       is_nop;
    logic       is_push;
    logic       is_pop;
    logic       is_alu;
    logic       is_cmp;
    logic       is_jmp;
    logic       is_jmpt;
    logic       is_halt;
    logic       is_legal;
    logic       pushes;
    logic [1:0] need_ops;
    logic [1:0] push_src;
    logic [3:0] alu_sel;
    logic       underflow;
    logic       overflow;
    logic       decode_fault;

    // The argument byte is routed straight to the datapath; the sequencer
    // never looks at it.
    logic unused_arg;
    assign unused_arg = ^ARG_IN;

    // The instruction register must load in the very cycle the memory
    // acknowledges, so this strobe is the only one derived combinationally.
    assign CTRL_REG_INSTR = (state == S_FETCH) && imem_ack;

    // Opcode classification and stack-depth checks for the latched opcode
    always_comb begin
        is_nop   = (instr == OP_NOP);
        is_push  = (instr == OP_PUSH);
        is_pop   = (instr == OP_POP);
        is_alu   = (instr >= OP_ALU_FIRST) && (instr <= OP_ALU_LAST);
        is_cmp   = (instr == OP_CMP);
        is_jmp   = (instr == OP_JMP);
        is_jmpt  = (instr == OP_JMPT);
        is_halt  = (instr == OP_HALT);
        is_legal = is_nop | is_push | is_pop | is_alu | is_cmp |
                   is_jmp | is_jmpt | is_halt;
        pushes   = is_push | is_alu | is_cmp;

        need_ops = 2'd0;
        if (is_pop || is_jmpt) begin
            need_ops = 2'd1;
        end else if (is_alu || is_cmp) begin
            need_ops = 2'd2;
        end

        push_src = SRC_ARG;
        if (is_alu) begin
            push_src = SRC_ALU;
        end else if (is_cmp) begin
            push_src = SRC_CMP;
        end

        alu_sel = instr[3:0];
        if (is_cmp) begin
            alu_sel = ULA_CMP;
        end else if (is_jmpt) begin
            alu_sel = ULA_TEST;
        end

        // ALU/CMP ops have a net stack change of -1 and so never overflow
        underflow    = ADDR_WIDTH'(need_ops) > TOS_IN;
        overflow     = is_push && (TOS_IN == ADDR_WIDTH'(STACK_DEPTH));
        decode_fault = underflow | overflow | ~is_legal;
    end

    // Sequencer: state register plus registered strobes for the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            instr           <= '0;
            imem_req        <= 1'b0;
            CTRL_REG_OP1    <= 1'b0;
            CTRL_REG_OP2    <= 1'b0;
            CTRL_STACK_PUSH <= 1'b0;
            CTRL_STACK_POP  <= 1'b0;
            SEL_STACK_SRC   <= SRC_ARG;
            SEL_ULA         <= 4'h0;
            CTRL_REG_PC     <= 1'b0;
            SEL_MUX_PC      <= 1'b0;
            halted          <= 1'b0;
            trap            <= 1'b0;
        end else begin
            // Strobes are single-cycle: cleared unless the next state asks
            imem_req        <= 1'b0;
            CTRL_REG_OP1    <= 1'b0;
            CTRL_REG_OP2    <= 1'b0;
            CTRL_STACK_PUSH <= 1'b0;
            CTRL_STACK_POP  <= 1'b0;
            SEL_STACK_SRC   <= SRC_ARG;
            SEL_ULA         <= 4'h0;
            CTRL_REG_PC     <= 1'b0;
            SEL_MUX_PC      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        halted   <= 1'b0;
                        imem_req <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (imem_ack) begin
                        state <= S_DECODE;
                        instr <= INSTR_IN;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end

                S_DECODE: begin
                    if (TRAP_EN && decode_fault) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                    end else if (is_halt) begin
                        state  <= S_IDLE;
                        halted <= 1'b1;
                    end else if (is_jmp) begin
                        state       <= S_JUMP;
                        CTRL_REG_PC <= 1'b1;
                        SEL_MUX_PC  <= 1'b1;
                    end else if (is_pop || is_alu || is_cmp || is_jmpt) begin
                        state          <= S_POP_A;
                        CTRL_STACK_POP <= 1'b1;
                        CTRL_REG_OP2   <= 1'b1;
                    end else begin
                        // NOP and PUSH; unlisted opcodes also land here when
                        // traps are not built in
                        state           <= S_WRITE;
                        CTRL_REG_PC     <= 1'b1;
                        CTRL_STACK_PUSH <= is_push;
                        SEL_STACK_SRC   <= SRC_ARG;
                    end
                end

                S_POP_A: begin
                    if (is_alu || is_cmp) begin
                        state          <= S_POP_B;
                        CTRL_STACK_POP <= 1'b1;
                        CTRL_REG_OP1   <= 1'b1;
                    end else if (is_jmpt) begin
                        state   <= S_EXEC;
                        SEL_ULA <= alu_sel;
                    end else begin
                        state       <= S_WRITE;
                        CTRL_REG_PC <= 1'b1;
                    end
                end

                S_POP_B: begin
                    state   <= S_EXEC;
                    SEL_ULA <= alu_sel;
                end

                S_EXEC: begin
                    if (TRAP_EN && is_alu && OVERFLOW_IN) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                    end else if (is_jmpt && COMPARE_IN) begin
                        state       <= S_JUMP;
                        CTRL_REG_PC <= 1'b1;
                        SEL_MUX_PC  <= 1'b1;
                    end else begin
                        // ALU select stays put through the write-back cycle
                        state           <= S_WRITE;
                        SEL_ULA         <= alu_sel;
                        CTRL_REG_PC     <= 1'b1;
                        CTRL_STACK_PUSH <= pushes;
                        SEL_STACK_SRC   <= push_src;
                    end
                end

                S_WRITE, S_JUMP: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end

                S_TRAP: begin
                    // Sticky until reset
                    state <= S_TRAP;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
